data_ram_arbiter: RTL and testbench
===================================

Name: data_ram_arbiter

Overview:
- Shares the single data_ram port (ce/we/addr/sel/data_i/data_o) between two requesters:
  - m0: the openmips data port (ram_*_o / ram_data_i), high priority.
  - m1: a secondary master (DMA or debug loader), low priority.
- Sits in openmips_min_sopc between the requesters and data_ram0.
- Fixed priority to m0, with an anti-starvation override for m1 and an optional lock for back-to-back sequences.
- The CPU stalls on m0_stall until it is served.

Parameters:
- ADDR_W, 32, address width (RegBus).
- DATA_W, 32, data width (RegBus).
- STARVE_MAX, 8, consecutive cycles m1 may wait while m0 wins before m1 is forced to win; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 access request; held until m0_ack.
- m0_we  in  1  m0 write enable.
- m0_addr  in  ADDR_W  m0 byte address.
- m0_sel  in  4  m0 byte lanes.
- m0_wdata  in  DATA_W  m0 write data.
- m0_rdata  out  DATA_W  m0 read data, valid with m0_ack.
- m0_ack  out  1  one-cycle completion pulse.
- m0_stall  out  1  m0_req & ~m0_ack; drives the pipeline stall request.
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_lock  in  1/1/ADDR_W/4/DATA_W/1  same meaning as m0; m1_lock requests grant retention.
- m1_rdata  out  DATA_W  m1 read data, valid with m1_ack.
- m1_ack  out  1  one-cycle completion pulse.
- ram_ce  out  1  to data_ram ce.
- ram_we  out  1  to data_ram we.
- ram_addr  out  ADDR_W  to data_ram addr.
- ram_sel  out  4  to data_ram sel.
- ram_wdata  out  DATA_W  to data_ram data_i.
- ram_rdata  in  DATA_W  from data_ram data_o (combinational read).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=0, starve_cnt=0, locked=0.
  - All ram_* outputs, acks and rdata = 0.
- States:
  - IDLE: no access in flight.
  - ACCESS: ram_ce=1 for exactly one cycle.
- Arbitration at each clk edge while in IDLE (or ACCESS with no lock retention):
  - locked=1 and m1_req=1: m1 wins.
  - Else starve_cnt==STARVE_MAX and m1_req=1: m1 wins.
  - Else m0_req=1: m0 wins.
  - Else m1_req=1: m1 wins.
  - Else go to IDLE.
- Winner's we/addr/sel/wdata are registered onto ram_*, owner is latched, and the next state is ACCESS.
- In ACCESS: owner's ack=1; owner's rdata=ram_rdata when ram_we=0, else 0. The write commits to data_ram at the end of that cycle. The other master's ack=0 and rdata=0.
- Latency: req sampled high at edge k -> ack high during cycle k+1. Back-to-back same master: a new arbitration happens on the ack edge. A master that keeps req high after its ack cycle is seen as a new request, so one access completes per cycle per winner.
- m0 stays on m0_stall while waiting; no combinational path from m0_req to ram_*.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each arbitration edge where m1_req=1 and m0 wins.
  - Cleared when m1 wins or m1_req=0.
- Lock:
  - locked is set on an edge where m1 wins with m1_lock=1, and cleared when m1 wins with m1_lock=0 or m1_req=0.
  - While locked, m0 is held off indefinitely; m1 owns the bus for consecutive accesses.
- Simultaneous requests with starve_cnt<STARVE_MAX and not locked: m0 wins.
- Request dropped before ack: protocol violation; the in-flight access still completes and ack is still pulsed.
- Reset mid-ACCESS: ram_ce drops immediately (asynchronous); no ack is pulsed.
- Address and width are passed unmodified; no alignment check (data_ram handles sel).

Test Plan:
- Reset: rst=0 with requests active -> all outputs 0; release rst, m0 read addr 0x10 -> ram_ce/ram_addr=0x10 next cycle, m0_ack=1, m0_rdata=RAM[0x10].
- m0 write 0x20, sel=4'b0011, wdata=0xDEADBEEF, then m1 read 0x20 -> m1_rdata=0x0000BEEF (low lanes only, prior RAM contents zero).
- Simultaneous m0/m1 requests, single access each -> m0 acked first, m1 acked next arbitration; m0_stall=0 after its ack.
- m0_req held continuously, m1_req held, STARVE_MAX=8 -> m1 acked on the 9th arbitration; starve_cnt returns to 0.
- m1 with m1_lock=1 for 4 accesses while m0_req=1 -> four consecutive m1_acks, m0_stall held; m0 acked on the arbitration after m1_lock drops.
- Assert rst=0 mid-ACCESS -> ram_ce=0 within the cycle, no ack; after release, state=IDLE and a pending m1 is served normally.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-master fixed-priority arbiter for the data_ram port
module data_ram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  output logic              m0_stall_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_lock_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_e            state_q;
  logic              owner_q;
  logic [7:0]        starve_cnt_q;
  logic              locked_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [3:0]        ram_sel_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              m0_ack_q;
  logic              m1_ack_q;

  logic grant_m0_d;
  logic grant_m1_d;

  // Lock and starvation both override m0's fixed priority, lock first.
  always_comb begin
    grant_m0_d = 1'b0;
    grant_m1_d = 1'b0;
    if (m1_req_i && (locked_q || starve_cnt_q == STARVE_LIM)) begin
      grant_m1_d = 1'b1;
    end else if (m0_req_i) begin
      grant_m0_d = 1'b1;
    end else if (m1_req_i) begin
      grant_m1_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      locked_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_sel_q    <= '0;
      ram_wdata_q  <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
    end else begin
      m0_ack_q <= grant_m0_d;
      m1_ack_q <= grant_m1_d;

      if (grant_m0_d) begin
        state_q     <= ACCESS;
        owner_q     <= 1'b0;
        ram_we_q    <= m0_we_i;
        ram_addr_q  <= m0_addr_i;
        ram_sel_q   <= m0_sel_i;
        ram_wdata_q <= m0_wdata_i;
      end else if (grant_m1_d) begin
        state_q     <= ACCESS;
        owner_q     <= 1'b1;
        ram_we_q    <= m1_we_i;
        ram_addr_q  <= m1_addr_i;
        ram_sel_q   <= m1_sel_i;
        ram_wdata_q <= m1_wdata_i;
      end else begin
        state_q  <= IDLE;
        ram_we_q <= 1'b0;
      end

      if (grant_m1_d || !m1_req_i) begin
        starve_cnt_q <= '0;
      end else if (grant_m0_d && starve_cnt_q != STARVE_LIM) begin
        starve_cnt_q <= starve_cnt_q + 8'd1;
      end

      if (grant_m1_d) begin
        locked_q <= m1_lock_i;
      end else if (!m1_req_i) begin
        locked_q <= 1'b0;
      end
    end
  end

  assign ram_ce_o    = (state_q == ACCESS);
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_sel_o   = ram_sel_q;
  assign ram_wdata_o = ram_wdata_q;

  assign m0_ack_o   = m0_ack_q;
  assign m1_ack_o   = m1_ack_q;
  assign m0_rdata_o = (m0_ack_q && !ram_we_q) ? ram_rdata_i : '0;
  assign m1_rdata_o = (m1_ack_q && !ram_we_q) ? ram_rdata_i : '0;
  assign m0_stall_o = m0_req_i & ~m0_ack_q;

  logic unused_owner;
  assign unused_owner = owner_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - directed self-checking bench for data_ram_arbiter
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_ack, m0_stall;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_sel;
  logic        m1_req, m1_we, m1_lock, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_sel;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  logic [31:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
    .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack), .m0_stall_o(m0_stall),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
    .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock), .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Behavioural data_ram: combinational read, byte-lane write at the clock edge.
  assign ram_rdata = ram_ce ? mem[ram_addr[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel[b]) mem[ram_addr[9:2]][b*8 +: 8] = ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int m0_acks;
  int m1_at;
  int lock_acks;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h1234_5678;

    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_sel = 4'hF; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_sel = 4'hF; m1_wdata = 32'h0;
    m1_lock = 1'b0;
    tick();
    tick();
    check_eq("rst_ram_ce", 32'(ram_ce), 32'h0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_m0_ack", 32'(m0_ack), 32'h0);
    check_eq("rst_m1_ack", 32'(m1_ack), 32'h0);
    check_eq("rst_m0_rdata", m0_rdata, 32'h0);

    // Single m0 read after reset release.
    m1_req = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("rd_ram_ce", 32'(ram_ce), 32'h1);
    check_eq("rd_ram_addr", ram_addr, 32'h10);
    check_eq("rd_m0_ack", 32'(m0_ack), 32'h1);
    check_eq("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    m0_req = 1'b0;
    tick();
    check_eq("rd_idle_ce", 32'(ram_ce), 32'h0);
    check_eq("rd_idle_ack", 32'(m0_ack), 32'h0);

    // m0 partial write, then m1 reads back the merged word.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_sel = 4'b0011; m0_wdata = 32'hDEAD_BEEF;
    tick();
    check_eq("wr_m0_ack", 32'(m0_ack), 32'h1);
    check_eq("wr_ram_we", 32'(ram_we), 32'h1);
    check_eq("wr_m0_rdata", m0_rdata, 32'h0);
    m0_req = 1'b0; m0_we = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_sel = 4'hF;
    tick();
    check_eq("wr_m1_ack", 32'(m1_ack), 32'h1);
    check_eq("wr_m1_rdata", m1_rdata, 32'h0000_BEEF);
    check_eq("wr_m0_ack_off", 32'(m0_ack), 32'h0);
    m1_req = 1'b0;
    tick();

    // Simultaneous single requests: m0 first, m1 on the next arbitration.
    m0_req = 1'b1; m0_addr = 32'h10; m0_sel = 4'hF;
    m1_req = 1'b1; m1_addr = 32'h20;
    tick();
    check_eq("sim_m0_ack", 32'(m0_ack), 32'h1);
    check_eq("sim_m1_ack0", 32'(m1_ack), 32'h0);
    check_eq("sim_m1_rdata0", m1_rdata, 32'h0);
    m0_req = 1'b0;
    check_eq("sim_m0_stall", 32'(m0_stall), 32'h0);
    tick();
    check_eq("sim_m1_ack", 32'(m1_ack), 32'h1);
    check_eq("sim_m1_rdata", m1_rdata, 32'h0000_BEEF);
    m1_req = 1'b0;
    tick();

    // Starvation: both held, m1 forced in on the 9th arbitration.
    m0_req = 1'b1; m1_req = 1'b1;
    m0_acks = 0; m1_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (m1_ack) begin
        m1_at = i;
        break;
      end
      if (m0_ack) m0_acks++;
    end
    check_eq("starve_m1_arb", 32'(m1_at), 32'd9);
    check_eq("starve_m0_acks", 32'(m0_acks), 32'd8);
    check_eq("starve_cnt_clr", 32'(dut.starve_cnt_q), 32'h0);
    m1_req = 1'b0;
    tick();
    check_eq("starve_m0_resume", 32'(m0_ack), 32'h1);
    m0_req = 1'b0;
    tick();

    // Lock: m1 keeps the bus for four accesses while m0 waits.
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h20;
    tick();
    check_eq("lock_m1_ack1", 32'(m1_ack), 32'h1);
    m0_req = 1'b1; m0_addr = 32'h10;
    lock_acks = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m1_ack && m0_stall) lock_acks++;
    end
    check_eq("lock_m1_acks", 32'(lock_acks), 32'd4);
    m1_req = 1'b0; m1_lock = 1'b0;
    tick();
    check_eq("lock_m0_ack", 32'(m0_ack), 32'h1);
    check_eq("lock_m0_rdata", m0_rdata, 32'h1234_5678);
    check_eq("lock_cleared", 32'(dut.locked_q), 32'h0);
    m0_req = 1'b0;
    tick();

    // Reset during an access: ce drops at once, pending m1 served afterwards.
    m1_req = 1'b1; m1_addr = 32'h20;
    tick();
    check_eq("mid_ram_ce", 32'(ram_ce), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ce", 32'(ram_ce), 32'h0);
    check_eq("mid_rst_ack", 32'(m1_ack), 32'h0);
    tick();
    check_eq("mid_hold_ack", 32'(m1_ack), 32'h0);
    rst_n = 1'b1;
    check_eq("mid_state_idle", 32'(dut.state_q), 32'h0);
    tick();
    check_eq("mid_m1_ack", 32'(m1_ack), 32'h1);
    check_eq("mid_m1_rdata", m1_rdata, 32'h0000_BEEF);
    m1_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
